// File: rtl/tug_pkg.sv
// Shared types and helpers for the tug-of-war light field.
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    WIN_HOLD  = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_RIGHT = 2'b01;
  localparam logic [1:0] WIN_LEFT  = 2'b10;

  localparam int SCORE_W = 3;

  // Increment that sticks at the ceiling instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                 input logic [SCORE_W-1:0] max);
    logic [SCORE_W-1:0] r;
    if (v >= max) begin
      r = v;
    end else begin
      r = v + 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tug_field_key_edge.sv
// Rising-edge detector for one player key; history register runs every cycle.
module key_edge
  import tug_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  logic key_prev_r;

  // Previous-cycle key level.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_prev_r <= 1'b0;
    end else begin
      key_prev_r <= key;
    end
  end

  assign press = key & ~key_prev_r;

endmodule

// File: rtl/tug_field.sv
// Tug-of-war playfield: a single light pushed left/right by key presses,
// round wins scored at the ends, game ends at SCORE_MAX wins.
module tug_field
  import tug_pkg::*;
#(
  parameter int NUM_LIGHTS  = 9,
  parameter int SCORE_MAX   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  res,
  input  logic                  L,
  input  logic                  R,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [2:0]            left_score,
  output logic [2:0]            right_score,
  output logic [1:0]            winner,
  output logic                  game_over
);

  localparam int POS_W  = $clog2(NUM_LIGHTS);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [POS_W-1:0]      CENTER    = POS_W'((NUM_LIGHTS - 1) / 2);
  localparam logic [POS_W-1:0]      POS_LEFT  = POS_W'(NUM_LIGHTS - 1);
  localparam logic [POS_W-1:0]      POS_RIGHT = POS_W'(0);
  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0]    SMAX      = SCORE_W'(SCORE_MAX);
  localparam logic [NUM_LIGHTS-1:0] LIGHT_ONE = {{(NUM_LIGHTS-1){1'b0}}, 1'b1};
  localparam logic [NUM_LIGHTS-1:0] ALL_ON    = {NUM_LIGHTS{1'b1}};

  state_t                  state_r, state_n_s;
  logic [POS_W-1:0]        pos_r, pos_n_s;
  logic [HOLD_W-1:0]       hold_r, hold_n_s;
  logic [SCORE_W-1:0]      lscore_r, lscore_n_s;
  logic [SCORE_W-1:0]      rscore_r, rscore_n_s;
  logic [1:0]              winner_r, winner_n_s;
  logic [NUM_LIGHTS-1:0]   lights_r, lights_n_s;
  logic                    game_over_r, game_over_n_s;
  logic                    l_press_s, r_press_s;

  key_edge u_left_edge (
    .clk   (clk),
    .reset (reset),
    .key   (L),
    .press (l_press_s)
  );

  key_edge u_right_edge (
    .clk   (clk),
    .reset (reset),
    .key   (R),
    .press (r_press_s)
  );

  // State, game registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= PLAY;
      pos_r       <= CENTER;
      hold_r      <= '0;
      lscore_r    <= '0;
      rscore_r    <= '0;
      winner_r    <= WIN_NONE;
      lights_r    <= LIGHT_ONE << CENTER;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      pos_r       <= pos_n_s;
      hold_r      <= hold_n_s;
      lscore_r    <= lscore_n_s;
      rscore_r    <= rscore_n_s;
      winner_r    <= winner_n_s;
      lights_r    <= lights_n_s;
      game_over_r <= game_over_n_s;
    end
  end

  // Next-state: res beats any press; an end press scores instead of moving.
  always_comb begin
    state_n_s  = state_r;
    pos_n_s    = pos_r;
    hold_n_s   = hold_r;
    lscore_n_s = lscore_r;
    rscore_n_s = rscore_r;
    winner_n_s = winner_r;
    if (res) begin
      state_n_s  = PLAY;
      pos_n_s    = CENTER;
      hold_n_s   = '0;
      winner_n_s = WIN_NONE;
      if (state_r == GAME_OVER) begin
        lscore_n_s = '0;
        rscore_n_s = '0;
      end else begin
        lscore_n_s = lscore_r;
      end
    end else begin
      case (state_r)
        PLAY: begin
          if (l_press_s && !r_press_s) begin
            if (pos_r == POS_LEFT) begin
              lscore_n_s = sat_inc(lscore_r, SMAX);
              winner_n_s = WIN_LEFT;
              hold_n_s   = '0;
              state_n_s  = WIN_HOLD;
            end else begin
              pos_n_s = pos_r + POS_W'(1);
            end
          end else if (r_press_s && !l_press_s) begin
            if (pos_r == POS_RIGHT) begin
              rscore_n_s = sat_inc(rscore_r, SMAX);
              winner_n_s = WIN_RIGHT;
              hold_n_s   = '0;
              state_n_s  = WIN_HOLD;
            end else begin
              pos_n_s = pos_r - POS_W'(1);
            end
          end else begin
            pos_n_s = pos_r;
          end
        end
        WIN_HOLD: begin
          if (hold_r == HOLD_LAST) begin
            hold_n_s = '0;
            if ((winner_r == WIN_LEFT && lscore_r == SMAX) ||
                (winner_r == WIN_RIGHT && rscore_r == SMAX)) begin
              state_n_s = GAME_OVER;
            end else begin
              state_n_s  = PLAY;
              pos_n_s    = CENTER;
              winner_n_s = WIN_NONE;
            end
          end else begin
            hold_n_s = hold_r + HOLD_W'(1);
          end
        end
        GAME_OVER: begin
          state_n_s = GAME_OVER;
        end
        default: begin
          state_n_s  = PLAY;
          pos_n_s    = CENTER;
          hold_n_s   = '0;
          winner_n_s = WIN_NONE;
        end
      endcase
    end
  end

  // Output decode from the upcoming state, registered alongside it.
  always_comb begin
    lights_n_s    = LIGHT_ONE << CENTER;
    game_over_n_s = 1'b0;
    case (state_n_s)
      PLAY, WIN_HOLD: begin
        lights_n_s = LIGHT_ONE << pos_n_s;
      end
      GAME_OVER: begin
        lights_n_s    = ALL_ON;
        game_over_n_s = 1'b1;
      end
      default: begin
        lights_n_s = LIGHT_ONE << CENTER;
      end
    endcase
  end

  assign lights      = lights_r;
  assign left_score  = lscore_r;
  assign right_score = rscore_r;
  assign winner      = winner_r;
  assign game_over   = game_over_r;

endmodule

// File: tb/tb_tug_field.sv
// Randomised plus directed bench for tug_field against a cycle-level game model.
module tb_tug_field;

  localparam int NL   = 9;
  localparam int SMAX = 2;
  localparam int HOLD = 4;
  localparam int CTR  = (NL - 1) / 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          res = 1'b0;
  logic          L = 1'b0;
  logic          R = 1'b0;
  logic [NL-1:0] lights;
  logic [2:0]    left_score, right_score;
  logic [1:0]    winner;
  logic          game_over;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 play, 1 showing a round win, 2 game over.
  int m_mode, m_pos, m_ls, m_rs, m_win, m_hold_left;
  bit m_pl, m_pr;

  tug_field #(.NUM_LIGHTS(NL), .SCORE_MAX(SMAX), .HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .res         (res),
    .L           (L),
    .R           (R),
    .lights      (lights),
    .left_score  (left_score),
    .right_score (right_score),
    .winner      (winner),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit l, input bit r, input bit rs, input bit rst);
    bit lp, rp;
    if (rst) begin
      m_mode = 0; m_pos = CTR; m_ls = 0; m_rs = 0; m_win = 0; m_hold_left = 0;
      m_pl = 1'b0; m_pr = 1'b0;
      return;
    end
    lp = l && !m_pl;
    rp = r && !m_pr;
    m_pl = l;
    m_pr = r;
    if (rs) begin
      if (m_mode == 2) begin m_ls = 0; m_rs = 0; end
      m_mode = 0; m_pos = CTR; m_win = 0;
    end else if (m_mode == 0) begin
      if (lp && !rp) begin
        if (m_pos == NL - 1) begin
          m_ls = (m_ls < SMAX) ? m_ls + 1 : m_ls;
          m_win = 2; m_mode = 1; m_hold_left = HOLD;
        end else m_pos++;
      end else if (rp && !lp) begin
        if (m_pos == 0) begin
          m_rs = (m_rs < SMAX) ? m_rs + 1 : m_rs;
          m_win = 1; m_mode = 1; m_hold_left = HOLD;
        end else m_pos--;
      end
    end else if (m_mode == 1) begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        if ((m_win == 2 ? m_ls : m_rs) == SMAX) m_mode = 2;
        else begin m_mode = 0; m_pos = CTR; m_win = 0; end
      end
    end
  endtask

  task automatic step(input bit l, input bit r, input bit rs, input bit rst);
    logic [NL-1:0] exp_lights;
    @(negedge clk);
    L = l; R = r; res = rs; reset = rst;
    @(posedge clk);
    model_step(l, r, rs, rst);
    #1;
    exp_lights = (m_mode == 2) ? {NL{1'b1}} : NL'(1) << m_pos;
    check("lights", 32'(lights), 32'(exp_lights));
    check("left_score", 32'(left_score), 32'(m_ls));
    check("right_score", 32'(right_score), 32'(m_rs));
    check("winner", 32'(winner), 32'(m_win));
    check("game_over", 32'(game_over), 32'(m_mode == 2));
  endtask

  task automatic press_l();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_r();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset values
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_lights", 32'(lights), 32'h010);
    check("rst_winner", 32'(winner), 32'h0);

    // Held L moves once
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("held_l", 32'(lights), 32'h020);
    end

    // Simultaneous rise cancels
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("both_lights", 32'(lights), 32'h010);
    check("both_scores", 32'({left_score, right_score}), 32'h0);

    // Left round win and hold
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) press_l();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("lwin_lights", 32'(lights), 32'h100);
    check("lwin_score", 32'(left_score), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("lwin_hold", 32'(winner), 32'h2);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("lwin_back_lights", 32'(lights), 32'h010);
    check("lwin_back_winner", 32'(winner), 32'h0);

    // Two right wins end the game
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 5; i++) press_r();
      for (int i = 0; i < HOLD; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("go_rscore", 32'(right_score), 32'h2);
    check("go_flag", 32'(game_over), 32'h1);
    check("go_lights", 32'(lights), 32'h1FF);
    for (int i = 0; i < 3; i++) begin press_l(); press_r(); end
    check("go_frozen", 32'({lights, winner}), 32'({9'h1FF, 2'b01}));

    // res in game over clears scores
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("res_scores", 32'({left_score, right_score}), 32'h0);
    check("res_lights", 32'(lights), 32'h010);
    check("res_go", 32'(game_over), 32'h0);

    // reset mid-hold
    for (int i = 0; i < 5; i++) press_l();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("midhold_lights", 32'(lights), 32'h010);
    check("midhold_score", 32'(left_score), 32'h0);
    check("midhold_winner", 32'(winner), 32'h0);

    // Random play
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) == 0), ($urandom_range(0, 399) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tug_field.md
TUG_FIELD -- requirements
Module: tug_field

Interface
REQ-001 Parameter NUM_LIGHTS, 9: number of playfield lights; odd, >=3; bit NUM_LIGHTS-1 is leftmost, bit 0 rightmost.
REQ-002 Parameter SCORE_MAX, 7: round wins that end the game; range 1..7.
REQ-003 Parameter HOLD_CYCLES, 4: cycles the winning end light is held before the next round; >=1.
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-006 res  input  1  synchronous round restart, active-high.
REQ-007 L  input  1  left player key, level, already synchronised to clk.
REQ-008 R  input  1  right player key, level, already synchronised to clk.
REQ-009 lights  output  NUM_LIGHTS  light pattern; one-hot in PLAY and WIN_HOLD.
REQ-010 left_score  output  3  left round wins, saturating at SCORE_MAX.
REQ-011 right_score  output  3  right round wins, saturating at SCORE_MAX.
REQ-012 winner  output  2  00 none, 01 right, 10 left; 11 never driven.
REQ-013 game_over  output  1  high only in state GAME_OVER.

Function
REQ-014 States: PLAY, WIN_HOLD, GAME_OVER; CENTER = (NUM_LIGHTS-1)/2.
REQ-015 Press = rising edge of key: key high this cycle, low the previous cycle; holding a key produces one press only.
REQ-016 PLAY, L press without R press: position +1, visible on lights after the same posedge that first samples L=1.
REQ-017 PLAY, R press without L press: position -1, same one-cycle latency.
REQ-018 PLAY, L press and R press in the same cycle: no move.
REQ-019 PLAY, L press at position NUM_LIGHTS-1: position unchanged, left_score +1, winner=10, go to WIN_HOLD.
REQ-020 PLAY, R press at position 0: position unchanged, right_score +1, winner=01, go to WIN_HOLD.
REQ-021 WIN_HOLD: lights shows the end light; all presses ignored; hold counter runs HOLD_CYCLES cycles.
REQ-022 WIN_HOLD expiry, incremented score < SCORE_MAX: go to PLAY; position=CENTER; winner=00.
REQ-023 WIN_HOLD expiry, incremented score = SCORE_MAX: go to GAME_OVER; winner kept; lights all ones.
REQ-024 GAME_OVER: presses ignored; all outputs frozen until res or reset.
REQ-025 Scores never exceed SCORE_MAX and never wrap.
REQ-026 res in PLAY or WIN_HOLD: PLAY, position=CENTER, winner=00, hold counter cleared; scores kept.
REQ-027 res in GAME_OVER: as REQ-026, and both scores also cleared to 0.
REQ-028 reset has priority over res; res has priority over any press in the same cycle.
REQ-029 Key history registers update every cycle, including in WIN_HOLD, GAME_OVER and during res, so a key held across a state change gives no press.

Reset
REQ-030 On reset: state PLAY, position CENTER, lights one-hot at CENTER, both scores 0, winner 00, game_over 0.
REQ-031 On reset: hold counter 0 and key history registers 0.
REQ-032 reset mid-hold or mid-game returns to the REQ-030/REQ-031 values on the next posedge.

Structure
REQ-033 Shared package tug_pkg holds the state enum (PLAY, WIN_HOLD, GAME_OVER) and the winner codes WIN_NONE=00, WIN_RIGHT=01, WIN_LEFT=10.
REQ-034 Sub-module key_edge (clk, reset, key -> press) is instantiated once for L and once for R.
REQ-035 Position counter width is $clog2(NUM_LIGHTS); hold counter width is $clog2(HOLD_CYCLES+1).

Verification
Bench parameters: NUM_LIGHTS=9, SCORE_MAX=2, HOLD_CYCLES=4.
REQ-036 reset, then L held high for 3 cycles -> lights moves 0x010 to 0x020 once and stays at 0x020.
REQ-037 L and R rise in the same cycle -> lights stays 0x010; scores stay 0.
REQ-038 5 separate L presses from centre -> lights 0x100, left_score=1, winner=10 for 4 cycles, then lights 0x010, winner=00.
REQ-039 Two right round wins -> right_score=2, game_over=1, lights 0x1FF; further presses change nothing.
REQ-040 res in GAME_OVER -> scores 0, lights 0x010, game_over=0 next cycle; reset asserted mid-WIN_HOLD -> all REQ-030/REQ-031 values.
